imultf_ss: RTL and testbench



---
 rtl/imult_pkg.sv | 16 +
 rtl/imult_step.sv | 29 ++
 rtl/imultf_ss.sv | 117 +++++++++++
 tb/tb_imultf_ss.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imult_pkg.sv
// Shared types and helpers for the iterative shift-add fractional multiplier.
package imult_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Iteration count is bits+1; anything beyond the operand width is treated as full width.
    function automatic int unsigned clamp_bits(input int unsigned bits, input int unsigned width);
        return (bits > width - 1) ? width - 1 : bits;
    endfunction

endpackage

// File: rtl/imult_step.sv
// One shift-add iteration: conditional add/subtract of the multiplicand into the upper
// accumulator half, then a one-bit arithmetic right shift of the (W+1)-bit result.
module imult_step #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic             sa_i,
    input  logic             sub_i,
    input  logic             lsb_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic             shift_o
);

    logic [WIDTH:0] base;
    logic [WIDTH:0] mx;
    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    // With a zero addend the sum is just the sign-extended upper half, so the shift-only
    // case falls out of the same datapath.
    assign base     = {sa_i & acc_hi_i[WIDTH-1], acc_hi_i};
    assign mx       = {sa_i & m_i[WIDTH-1], m_i};
    assign addend   = lsb_i ? mx : '0;
    assign sum      = sub_i ? (base - addend) : (base + addend);
    assign acc_hi_o = sum[WIDTH:1];
    assign shift_o  = sum[0];

endmodule

// File: rtl/imultf_ss.sv
// Iterative signed/unsigned fractional multiplier: n = bits+1 iterations, one per cycle,
// with abort, a one-cycle done strobe and a product register held until the next start.
module imultf_ss
    import imult_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned BW    = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               go_i,
    input  logic               abort_i,
    input  logic               sign_a_i,
    input  logic               sign_b_i,
    input  logic [BW-1:0]      bits_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] p_o
);

    if (WIDTH < 4 || WIDTH > MAX_WIDTH) begin : gen_width_check
        $error("imultf_ss: WIDTH out of supported range");
    end

    state_e             state_q, state_d;
    logic [BW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               done_q, done_d;

    logic               last_iter;
    logic               step_sub;
    logic [WIDTH-1:0]   step_hi;
    logic               step_shift;

    assign last_iter = (count_q == '0);
    // The final multiplier bit carries negative weight when b is signed.
    assign step_sub  = sb_q & last_iter;

    imult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_hi_i (acc_q[2*WIDTH-1:WIDTH]),
        .m_i      (m_q),
        .sa_i     (sa_q),
        .sub_i    (step_sub),
        .lsb_i    (acc_q[0]),
        .acc_hi_o (step_hi),
        .shift_o  (step_shift)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        m_d     = m_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go_i && !abort_i) begin
                    m_d     = a_i;
                    sa_d    = sign_a_i;
                    sb_d    = sign_b_i;
                    count_d = BW'(clamp_bits(32'(bits_i), WIDTH));
                    acc_d   = {{WIDTH{1'b0}}, b_i};
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort leaves the partial accumulator untouched in p.
                if (abort_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = {step_hi, step_shift, acc_q[WIDTH-1:1]};
                    if (last_iter) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q - BW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            m_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == StRun);
    assign done_o = done_q;
    assign p_o    = acc_q;

endmodule

// File: tb/tb_imultf_ss.sv
// Directed bench for imultf_ss at WIDTH=8 with hand-computed products and timing.
module tb_imultf_ss;

    localparam int unsigned W  = 8;
    localparam int unsigned BW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          abort;
    logic          sign_a;
    logic          sign_b;
    logic [BW-1:0] bits;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imultf_ss #(
        .WIDTH(W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .go_i     (go),
        .abort_i  (abort),
        .sign_a_i (sign_a),
        .sign_b_i (sign_b),
        .bits_i   (bits),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .p_o      (p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents an operation and pulses go across one edge.
    task automatic start(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] nb,
                         input logic sav, input logic sbv);
        a      = av;
        b      = bv;
        bits   = nb;
        sign_a = sav;
        sign_b = sbv;
        go     = 1'b1;
        tick();
        go     = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done && cycles < 40);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;

        rst = 1'b1; go = 1'b0; abort = 1'b0; sign_a = 1'b0; sign_b = 1'b0;
        bits = '0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_done", 16'(done), 16'h0);
        chk("reset_p", p, 16'h0000);

        // Unsigned full precision.
        start(8'd200, 8'd200, 3'd7, 1'b0, 1'b0);
        chk("uu_busy", 16'(busy), 16'h1);
        wait_done(cyc);
        chk("uu_latency", 16'(cyc), 16'd8);
        chk("uu_p", p, 16'h9C40);
        chk("uu_busy_fall", 16'(busy), 16'h0);
        tick();
        chk("uu_done_pulse", 16'(done), 16'h0);
        chk("uu_p_hold", p, 16'h9C40);

        start(8'hFD, 8'h05, 3'd7, 1'b1, 1'b0);
        wait_done(cyc);
        chk("su_m3x5", p, 16'hFFF1);

        start(8'h80, 8'hFF, 3'd7, 1'b1, 1'b0);
        wait_done(cyc);
        chk("su_m128x255", p, 16'h8080);

        start(8'h03, 8'hFE, 3'd7, 1'b0, 1'b1);
        wait_done(cyc);
        chk("us_3xm2", p, 16'hFFFA);

        start(8'hFD, 8'hFB, 3'd7, 1'b1, 1'b1);
        wait_done(cyc);
        chk("ss_m3xm5", p, 16'h000F);

        start(8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
        wait_done(cyc);
        chk("ss_m128xm128", p, 16'h4000);

        // Fractional: 4 iterations, unconsumed b bits land in the low nibble.
        start(8'h40, 8'h0B, 3'd3, 1'b0, 1'b0);
        wait_done(cyc);
        chk("frac_latency", 16'(cyc), 16'd4);
        chk("frac_p", p, 16'h2C00);

        start(8'h40, 8'h5B, 3'd3, 1'b0, 1'b0);
        wait_done(cyc);
        chk("frac_low_bits", p, 16'h2C05);

        start(8'h03, 8'h0E, 3'd3, 1'b0, 1'b1);
        wait_done(cyc);
        chk("frac_signed_b", p, 16'hFFA0);

        // go during busy is ignored and operands are already latched.
        start(8'd200, 8'd200, 3'd7, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        start(8'h01, 8'h01, 3'd0, 1'b1, 1'b1);
        wait_done(cyc);
        chk("busy_go_latency", 16'(cyc), 16'd4);
        chk("busy_go_p", p, 16'h9C40);

        // Back-to-back start in the done cycle.
        start(8'd3, 8'd4, 3'd7, 1'b0, 1'b0);
        chk("b2b_busy", 16'(busy), 16'h1);
        chk("b2b_done_low", 16'(done), 16'h0);
        wait_done(cyc);
        chk("b2b_latency", 16'(cyc), 16'd8);
        chk("b2b_p", p, 16'h000C);

        // go with abort in IDLE does not start.
        tick();
        abort = 1'b1;
        start(8'd5, 8'd5, 3'd7, 1'b0, 1'b0);
        abort = 1'b0;
        chk("idle_abort_busy", 16'(busy), 16'h0);
        chk("idle_abort_p", p, 16'h000C);

        // Abort in the 3rd RUN cycle keeps the two-iteration partial.
        start(8'h10, 8'h03, 3'd7, 1'b0, 1'b0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_partial", p, 16'h0C00);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_done", 16'(saw_done), 16'h0);
        chk("abort_p_hold", p, 16'h0C00);

        // Reset mid-run discards the operation.
        start(8'd200, 8'd200, 3'd7, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_p", p, 16'h0000);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        chk("rst_no_done", 16'(saw_done), 16'h0);

        start(8'd3, 8'd4, 3'd7, 1'b0, 1'b0);
        wait_done(cyc);
        chk("post_rst_latency", 16'(cyc), 16'd8);
        chk("post_rst_p", p, 16'h000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
